// File: rtl/haz_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller:
// FSM state encodings and the control-output bundle constants.
package haz_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_HOLD  = 2'd1,
    S_MDU_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_sel;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_out_t;

  localparam ctrl_out_t IDLE_OUT  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_out_t STALL_OUT = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_out_t FLUSH_OUT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-source inputs and pipeline-control outputs of the
// stall controller; slave = controller side, master = pipeline side.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             lu_hazard;
  logic             mdu_start;
  logic             mdu_done;
  logic             br_taken;
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             Control_Unit_Sel;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic             mdu_timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output lu_hazard, mdu_start, mdu_done, br_taken,
    input  PCWrite, IF_ID_Write, Control_Unit_Sel,
    input  IF_ID_Flush, ID_EX_Flush, mdu_timeout_err,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  lu_hazard, mdu_start, mdu_done, br_taken,
    output PCWrite, IF_ID_Write, Control_Unit_Sel,
    output IF_ID_Flush, ID_EX_Flush, mdu_timeout_err,
    output stall_cnt, flush_cnt
  );
endinterface

// File: rtl/haz_sat_counter.sv
// Saturating event counter with synchronous active-high reset.
module haz_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: load-use, MDU wait with watchdog, branch flush.
// HAZ_PERF_CNT_EN enables the stall/flush performance counters.
module pipeline_stall_controller
  import haz_ctrl_pkg::*;
#(
  parameter int MDU_MAX_CYC = 32,
  parameter int CNT_W       = 16
) (
  input logic                         clk,
  input logic                         rst,
  pipeline_stall_controller_if.slave  bus
);
  localparam int WW = $clog2(MDU_MAX_CYC) + 1;
  localparam logic [WW-1:0] WLAST = WW'(MDU_MAX_CYC - 1);

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic            err_q, err_d;
  ctrl_out_t       out;
  logic            flush_ev;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    out      = IDLE_OUT;
    flush_ev = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (bus.br_taken) begin
          out      = FLUSH_OUT;
          flush_ev = 1'b1;
        end else if (bus.mdu_start && bus.mdu_done) begin
          out = IDLE_OUT;
        end else if (bus.mdu_start) begin
          out     = STALL_OUT;
          state_d = S_MDU_WAIT;
          wcnt_d  = WW'(1);
        end else if (bus.lu_hazard) begin
          out     = STALL_OUT;
          state_d = S_LU_HOLD;
        end
      end
      S_LU_HOLD: begin
        state_d = S_RUN;
        if (bus.br_taken) begin
          out      = FLUSH_OUT;
          flush_ev = 1'b1;
        end
      end
      S_MDU_WAIT: begin
        if (bus.mdu_done) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q >= WLAST) begin
          state_d = S_RUN;
          wcnt_d  = '0;
          err_d   = 1'b1;
        end else begin
          out    = STALL_OUT;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = '0;
      end
    endcase
    // Reset wins over everything, including an in-flight wait
    if (rst) begin
      out      = IDLE_OUT;
      flush_ev = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.PCWrite          = out.pc_write;
  assign bus.IF_ID_Write      = out.if_id_write;
  assign bus.Control_Unit_Sel = out.ctrl_sel;
  assign bus.IF_ID_Flush      = out.if_id_flush;
  assign bus.ID_EX_Flush      = out.id_ex_flush;
  assign bus.mdu_timeout_err  = err_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_w, flush_cnt_w;

  haz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (!out.pc_write),
    .cnt_o (stall_cnt_w)
  );

  haz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_ev),
    .cnt_o (flush_cnt_w)
  );

  assign bus.stall_cnt = stall_cnt_w;
  assign bus.flush_cnt = flush_cnt_w;
`else
  logic unused_flush_ev;
  assign unused_flush_ev = flush_ev;
  assign bus.stall_cnt   = '0;
  assign bus.flush_cnt   = '0;
`endif
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MDU_MAX_CYC=8, CNT_W=4).
module tb_pipeline_stall_controller;
  localparam int MAXC = 8;
  localparam int CW   = 4;
  localparam logic [4:0] IDLE  = 5'b11100;
  localparam logic [4:0] STALL = 5'b00000;
  localparam logic [4:0] FLUSH = 5'b11111;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   es = 0;
  int   ef = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(CW)) bus ();

  pipeline_stall_controller #(
    .MDU_MAX_CYC (MAXC),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [4:0] outs();
    return {bus.PCWrite, bus.IF_ID_Write, bus.Control_Unit_Sel,
            bus.IF_ID_Flush, bus.ID_EX_Flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic l, input logic s,
                        input logic d, input logic b);
    bus.lu_hazard = l;
    bus.mdu_start = s;
    bus.mdu_done  = d;
    bus.br_taken  = b;
  endtask

  // called at posedge+1; checks mid-cycle, returns at next posedge+1
  task automatic cyc(input logic l, input logic s, input logic d,
                     input logic b, input logic [4:0] exp,
                     input string tag);
    set_in(l, s, d, b);
    #4;
    chk(tag, 32'(outs()), 32'(exp));
    if (!exp[4]) es = (es == 15) ? 15 : es + 1;
    if (exp[1])  ef = (ef == 15) ? 15 : ef + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
`ifdef HAZ_PERF_CNT_EN
    chk({tag, "_stall"}, 32'(bus.stall_cnt), 32'(es));
    chk({tag, "_flush"}, 32'(bus.flush_cnt), 32'(ef));
`else
    chk({tag, "_stall"}, 32'(bus.stall_cnt), 32'd0);
    chk({tag, "_flush"}, 32'(bus.flush_cnt), 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0);
    @(posedge clk);
    #1;
    set_in(1, 1, 0, 1);
    #4;
    chk("rst_idle", 32'(outs()), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0);
    chk("rst_err", 32'(bus.mdu_timeout_err), 32'd0);
    chk_cnt("rst");

    cyc(1, 0, 0, 0, STALL, "lu_stall");
    cyc(1, 0, 0, 0, IDLE,  "lu_mask");
    cyc(0, 0, 0, 0, IDLE,  "lu_idle");
    chk_cnt("lu");

    cyc(0, 1, 0, 0, STALL, "mdu_c0");
    cyc(0, 0, 0, 0, STALL, "mdu_c1");
    cyc(1, 1, 0, 1, STALL, "mdu_ign");
    cyc(0, 0, 0, 0, STALL, "mdu_c3");
    cyc(0, 0, 0, 0, STALL, "mdu_c4");
    cyc(0, 0, 1, 0, IDLE,  "mdu_done");
    cyc(1, 0, 0, 0, STALL, "mdu_run");
    cyc(0, 0, 0, 0, IDLE,  "mdu_after");
    chk("mdu_err", 32'(bus.mdu_timeout_err), 32'd0);
    chk_cnt("mdu");

    cyc(0, 1, 1, 0, IDLE,  "mdu_zero");
    cyc(1, 0, 0, 0, STALL, "zero_run");
    cyc(0, 0, 0, 0, IDLE,  "zero_hold");

    cyc(1, 0, 0, 0, STALL, "hold_lu");
    cyc(1, 0, 0, 1, FLUSH, "hold_br");
    cyc(1, 0, 0, 0, STALL, "hold_run");
    cyc(0, 0, 0, 0, IDLE,  "hold_idle");

    cyc(1, 1, 0, 1, FLUSH, "br_all");
    cyc(0, 0, 0, 0, IDLE,  "br_nowait");
    cyc(1, 0, 0, 0, STALL, "br_run");
    cyc(0, 0, 0, 0, IDLE,  "br_idle");
    chk_cnt("br");

    cyc(0, 1, 0, 0, STALL, "to_c0");
    for (int i = 1; i < MAXC - 1; i++)
      cyc(0, 0, 0, 0, STALL, "to_wait");
    cyc(0, 0, 0, 0, IDLE,  "to_rel");
    chk("to_err", 32'(bus.mdu_timeout_err), 32'd1);
    cyc(1, 0, 0, 0, STALL, "to_run");
    cyc(0, 0, 0, 0, IDLE,  "to_idle");
    chk("to_sticky", 32'(bus.mdu_timeout_err), 32'd1);
    chk_cnt("to");

    cyc(0, 1, 0, 0, STALL, "rw_c0");
    cyc(0, 0, 0, 0, STALL, "rw_c1");
    rst = 1'b1;
    set_in(1, 0, 0, 0);
    #4;
    chk("rw_idle", 32'(outs()), 32'(IDLE));
    @(posedge clk);
    #1;
    rst = 1'b0;
    es  = 0;
    ef  = 0;
    chk("rw_err", 32'(bus.mdu_timeout_err), 32'd0);
    chk_cnt("rw");
    cyc(0, 0, 0, 0, IDLE,  "rw_run");
    cyc(0, 1, 0, 0, STALL, "rw2_c0");
    for (int i = 1; i < MAXC - 1; i++)
      cyc(0, 0, 0, 0, STALL, "rw2_wait");
    cyc(0, 0, 1, 0, IDLE,  "rw2_done");
    chk("rw2_err", 32'(bus.mdu_timeout_err), 32'd0);

    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 0, STALL, "sat_lu");
      cyc(0, 0, 0, 0, IDLE,  "sat_idle");
    end
    chk_cnt("sat");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Sequential stall/flush controller for the 5-stage MIPS pipeline. It sits between the combinational load-use hazard detector, the multi-cycle multiply/divide unit (MDU) and EX-stage branch resolution. It drives the pipeline-register write enables, the control-mux select and the flush strobes. It adds multi-cycle stall sequencing, branch flush priority, an MDU timeout watchdog and optional performance counters.

## Interface
Parameters:
- MDU_MAX_CYC, 32: maximum MDU wait cycles before forced release (≥2).
- CNT_W, 16: width of the performance counters.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- lu_hazard  in  1  load-use hazard from the hazard detector.
- mdu_start  in  1  multi-cycle MDU op entering EX this cycle.
- mdu_done  in  1  MDU result valid this cycle.
- br_taken  in  1  branch/jump resolved taken in EX.
- PCWrite  out  1  PC write enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- Control_Unit_Sel  out  1  1 = pass decoded control, 0 = insert bubble.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- ID_EX_Flush  out  1  clear ID/EX to NOP.
- mdu_timeout_err  out  1  sticky watchdog error.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.
- flush_cnt  out  CNT_W  saturating count of flush events.

## Operation
- FSM states: RUN, LU_HOLD, MDU_WAIT. Outputs are Mealy (state + current inputs).
- Idle outputs: PCWrite=1, IF_ID_Write=1, Control_Unit_Sel=1, both flushes 0.

RUN, evaluated in priority order:
- br_taken: IF_ID_Flush=1 and ID_EX_Flush=1; PCWrite=1. lu_hazard and mdu_start are ignored this cycle because the ID instruction is discarded. Next state RUN. flush_cnt+1.
- mdu_start & mdu_done: zero-wait operation. Idle outputs; stay RUN.
- mdu_start & !mdu_done: stall this cycle (PCWrite=0, IF_ID_Write=0, Control_Unit_Sel=0). Next state MDU_WAIT; wait counter = 1.
- lu_hazard: stall this cycle (same three outputs 0). Next state LU_HOLD.
- Otherwise: idle outputs.

LU_HOLD:
- Idle outputs. lu_hazard is masked because a bubble now occupies EX.
- br_taken is handled exactly as in RUN.
- Next state RUN unconditionally.

MDU_WAIT:
- mdu_done=0 and wait counter < MDU_MAX_CYC-1: stall; counter+1; stay in MDU_WAIT.
- mdu_done=1: idle outputs this cycle; next state RUN; counter cleared.
- mdu_done=0 and counter = MDU_MAX_CYC-1: forced release with idle outputs; mdu_timeout_err←1; next state RUN.
- br_taken, lu_hazard and mdu_start are ignored in this state.

Status and counters:
- mdu_timeout_err is cleared only by rst.
- stall_cnt increments in every cycle where PCWrite=0. Both counters saturate at all-ones.
- Wait counter width: $clog2(MDU_MAX_CYC)+1.

## Timing
- Outputs change combinationally with inputs; the state updates at the clk rising edge.
- Load-use stall: exactly 1 cycle.
- MDU stall: N cycles when mdu_done arrives N cycles after mdu_start. The maximum is MDU_MAX_CYC-1 stall cycles.
- Branch flush: one cycle, same cycle as br_taken.
- Reset: while rst=1, outputs are forced to idle values. After the reset edge: state RUN, wait counter 0, mdu_timeout_err 0, stall_cnt 0, flush_cnt 0.
- Reset asserted mid-MDU_WAIT aborts the wait and sets no error.

## Configuration
- HAZ_PERF_CNT_EN defined: stall_cnt and flush_cnt are implemented as described.
- HAZ_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are synthesized. All other behaviour is identical.

## Structure
- Package haz_ctrl_pkg holds the state encodings S_RUN=2'd0, S_LU_HOLD=2'd1 and S_MDU_WAIT=2'd2.
- Package haz_ctrl_pkg also holds the idle-output constant.
- Sub-module haz_sat_counter: parameterised CNT_W saturating counter with inc and synchronous rst. It is instantiated twice under HAZ_PERF_CNT_EN.

## Test plan
- Load-use: lu_hazard=1 for 2 cycles → 1 stall cycle (PCWrite=0, Control_Unit_Sel=0), then PCWrite=1 with lu_hazard masked; stall_cnt=1.
- MDU wait: mdu_start at cycle 0, mdu_done at cycle 5 → stalls on cycles 0–4; PCWrite=1 at cycle 5; state back to RUN at cycle 6.
- Timeout: MDU_MAX_CYC=8, mdu_done held 0 → 7 stall cycles, then forced release with mdu_timeout_err=1, which stays 1 until rst.
- Simultaneous events: br_taken=1, lu_hazard=1 and mdu_start=1 in the same cycle → both flushes asserted, PCWrite=1, no stall; flush_cnt=1; next state RUN.
- Reset mid-wait: rst asserted during MDU_WAIT → idle outputs, state RUN, counters 0, mdu_timeout_err 0.
- Saturation: CNT_W=4, 20 load-use stalls → stall_cnt=15.
